// File: rtl/grid_color_ctrl_if.sv
// grid_color_ctrl_if: request, clear, blanking and renderer read-port signals
// shared between the keypad/renderer side (master) and the grid controller (slave).
interface grid_color_ctrl_if #(
    parameter int unsigned DEPTH = 4
);
    logic                    req_valid;
    logic                    req_ready;
    logic [3:0]              req_pos;
    logic [2:0]              req_color;
    logic                    clr_req;
    logic [2:0]              clr_color;
    logic                    blank;
    logic [3:0]              rd_pos;
    logic [2:0]              rd_color;
    logic                    busy;
    logic [$clog2(DEPTH):0]  pending;

    modport master (
        output req_valid, req_pos, req_color, clr_req, clr_color, blank, rd_pos,
        input  req_ready, rd_color, busy, pending
    );

    modport slave (
        input  req_valid, req_pos, req_color, clr_req, clr_color, blank, rd_pos,
        output req_ready, rd_color, busy, pending
    );
endinterface

// File: rtl/grid_color_ctrl.sv
// grid_color_ctrl: FIFO-buffered write scheduler for the 4x4 colour-grid bank.
// Updates are committed only while blank=1, one bank write per cycle; queued
// requests drain before a pending whole-grid clear sweep starts.
// Optional clear path compiled in with macro GRID_CLEAR_EN.
module grid_color_ctrl #(
    parameter int unsigned DEPTH       = 4,
    parameter logic [2:0]  RESET_COLOR = 3'd0
) (
    input logic              clk,
    input logic              rst,
    grid_color_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BLANK,
        S_COMMIT,
        S_CLEAR
    } state_t;

    logic [3:0]    r_fifo_pos   [DEPTH];
    logic [2:0]    r_fifo_color [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [2:0]    r_bank [16];
    state_t        r_state;
    state_t        w_state_next;

    logic          w_ready;
    logic          w_push;
    logic          w_commit;
    logic          w_clear_wr;
    logic          w_fifo_empty;
    logic [CW-1:0] w_count_next;
    logic          w_clr_active;
    logic          w_clr_pend_next;
    logic [2:0]    w_clr_color;
    logic [3:0]    w_sweep;

    assign w_fifo_empty = (r_count == '0);
    assign w_ready      = (r_count != CW'(DEPTH)) & ~w_clr_active;
    assign w_push       = bus.req_valid & w_ready;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_commit);

`ifdef GRID_CLEAR_EN
    logic       r_clr_pend;
    logic [2:0] r_clr_color;
    logic [3:0] r_sweep;

    // Clear stays pending until the 16th fill write; a new request is accepted only when none is outstanding
    assign w_clr_pend_next = (r_clr_pend & ~(w_clear_wr & (r_sweep == 4'd15)))
                           | (bus.clr_req & ~r_clr_pend);

    // Latch the fill colour on acceptance and advance the sweep counter on each fill write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_pend  <= 1'b0;
            r_clr_color <= '0;
            r_sweep     <= '0;
        end else begin
            r_clr_pend <= w_clr_pend_next;
            if (bus.clr_req && !r_clr_pend) begin
                r_clr_color <= bus.clr_color;
            end
            if (w_clear_wr) begin
                r_sweep <= r_sweep + 4'd1;
            end
        end
    end

    assign w_clr_active = r_clr_pend;
    assign w_clr_color  = r_clr_color;
    assign w_sweep      = r_sweep;
`else
    logic w_unused_clr;
    assign w_unused_clr    = ^{bus.clr_req, bus.clr_color};
    assign w_clr_pend_next = 1'b0;
    assign w_clr_active    = 1'b0;
    assign w_clr_color     = '0;
    assign w_sweep         = '0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state classifies the work left after this edge; blank gating of writes is applied in the output logic
    always_comb begin
        w_state_next = r_state;
        if ((w_count_next == '0) && !w_clr_pend_next) begin
            w_state_next = S_IDLE;
        end else if (!bus.blank) begin
            w_state_next = S_WAIT_BLANK;
        end else if (w_count_next != '0) begin
            w_state_next = S_COMMIT;
        end else begin
            w_state_next = S_CLEAR;
        end
    end

    // Bank write strobes: FIFO entries take priority over the clear sweep, and nothing is written outside blank
    always_comb begin
        w_commit   = 1'b0;
        w_clear_wr = 1'b0;
        if (r_state != S_IDLE) begin
            w_commit   = bus.blank & ~w_fifo_empty;
            w_clear_wr = bus.blank & w_fifo_empty & w_clr_active;
        end
    end

    // FIFO storage written on push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pos[r_wr_ptr]   <= bus.req_pos;
            r_fifo_color[r_wr_ptr] <= bus.req_color;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_commit) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    // Colour bank: reset fill, FIFO head commit, or one clear-sweep cell per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) begin
                r_bank[i] <= RESET_COLOR;
            end
        end else if (w_commit) begin
            r_bank[r_fifo_pos[r_rd_ptr]] <= r_fifo_color[r_rd_ptr];
        end else if (w_clear_wr) begin
            r_bank[w_sweep] <= w_clr_color;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rd_color  = r_bank[bus.rd_pos];
    assign bus.busy      = ~w_fifo_empty | w_clr_active;
    assign bus.pending   = r_count;
endmodule

// File: tb/tb_grid_color_ctrl.sv
// tb_grid_color_ctrl: directed scenarios plus randomized traffic for
// grid_color_ctrl, checked every cycle against a queue-based reference model.
// Clear scenarios are included when GRID_CLEAR_EN is defined.
module tb_grid_color_ctrl;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    grid_color_ctrl_if #(.DEPTH(DEPTH)) bus ();

    grid_color_ctrl #(
        .DEPTH       (DEPTH),
        .RESET_COLOR (3'd0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #50 clk = ~clk;

    // Reference model: bank contents, request queue, clear state
    logic [2:0] m_bank [16];
    logic [6:0] m_q [$];
    bit         m_clr;
    logic [2:0] m_clr_color;
    int         m_sweep;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit m_ready();
        return (m_q.size() != DEPTH) && !m_clr;
    endfunction

    // Apply one clock edge to the model using the inputs held across that edge
    task automatic model_edge();
        bit         ready_pre;
        logic [6:0] e;
`ifdef GRID_CLEAR_EN
        bit         clr_pre;
        clr_pre = m_clr;
`endif
        ready_pre = m_ready();
        if (rst) begin
            foreach (m_bank[i]) m_bank[i] = 3'd0;
            m_q.delete();
            m_clr   = 1'b0;
            m_sweep = 0;
        end else begin
            if (bus.blank && m_q.size() > 0) begin
                e = m_q.pop_front();
                m_bank[e[6:3]] = e[2:0];
            end else if (bus.blank && m_clr) begin
                m_bank[m_sweep] = m_clr_color;
                m_sweep++;
                if (m_sweep == 16) begin
                    m_clr   = 1'b0;
                    m_sweep = 0;
                end
            end
            if (bus.req_valid && ready_pre) m_q.push_back({bus.req_pos, bus.req_color});
`ifdef GRID_CLEAR_EN
            if (bus.clr_req && !clr_pre) begin
                m_clr       = 1'b1;
                m_clr_color = bus.clr_color;
            end
`endif
        end
    endtask

    // Check outputs against the model with current inputs, then advance one clock
    task automatic step();
        #1;
        check("req_ready", bus.req_ready, m_ready());
        check("pending", bus.pending, m_q.size());
        check("busy", bus.busy, (m_q.size() != 0) || m_clr);
        check("rd_color", bus.rd_color, m_bank[bus.rd_pos]);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Read every cell; compare against a constant or the model
    task automatic read_all(input bit use_const, input logic [2:0] c);
        for (int p = 0; p < 16; p++) begin
            bus.rd_pos = 4'(p);
            #1;
            check($sformatf("cell%0d", p), bus.rd_color, use_const ? c : m_bank[p]);
        end
    endtask

    task automatic push(input logic [3:0] pos, input logic [2:0] color);
        bus.req_valid = 1'b1;
        bus.req_pos   = pos;
        bus.req_color = color;
        step();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_pos   = '0;
        bus.req_color = '0;
        bus.clr_req   = 1'b0;
        bus.clr_color = '0;
        bus.blank     = 1'b0;
        bus.rd_pos    = '0;
        m_clr         = 1'b0;
        m_sweep       = 0;
        m_clr_color   = '0;

        // Reset held for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_edge();
        #1;
        rst = 1'b0;
        read_all(1'b1, 3'd0);
        check("rst_ready", bus.req_ready, 1);
        check("rst_pending", bus.pending, 0);
        check("rst_busy", bus.busy, 0);

        // Deferred commit: nothing written while blank=0
        bus.rd_pos = 4'd5;
        push(4'd5, 3'b100);
        check("defer_pending", bus.pending, 1);
        repeat (100) step();
        check("defer_hold", bus.rd_color, 0);
        bus.blank = 1'b1;
        step();
        check("defer_cell", bus.rd_color, 3'b100);
        check("defer_drained", bus.pending, 0);

        // Same-cell ordering: last write wins
        bus.rd_pos = 4'd7;
        push(4'd7, 3'd1);
        push(4'd7, 3'd2);
        step();
        step();
        check("same_cell", bus.rd_color, 3'd2);

        // Backpressure: four fill the FIFO, fifth waits for space
        bus.blank = 1'b0;
        for (int i = 0; i < 4; i++) push(4'(8 + i), 3'(1 + i));
        check("bp_ready", bus.req_ready, 0);
        check("bp_pending", bus.pending, 4);
        bus.req_valid = 1'b1;
        bus.req_pos   = 4'd12;
        bus.req_color = 3'd5;
        step();
        bus.blank = 1'b1;
        step();
        step();
        bus.req_valid = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 5; i++) begin
            bus.rd_pos = 4'(8 + i);
            #1;
            check($sformatf("bp_cell%0d", 8 + i), bus.rd_color, 1 + i);
        end

`ifdef GRID_CLEAR_EN
        // Clear behind two queued requests, paused after 8 fill cycles
        bus.blank = 1'b0;
        push(4'd1, 3'd5);
        push(4'd2, 3'd6);
        bus.clr_req   = 1'b1;
        bus.clr_color = 3'b010;
        step();
        bus.clr_req = 1'b0;
        check("clr_ready", bus.req_ready, 0);
        check("clr_busy", bus.busy, 1);
        bus.blank = 1'b1;
        repeat (10) step();
        bus.blank = 1'b0;
        repeat (3) step();
        for (int p = 0; p < 8; p++) begin
            bus.rd_pos = 4'(p);
            #1;
            check($sformatf("clr_lo%0d", p), bus.rd_color, 3'b010);
        end
        bus.rd_pos = 4'd9;
        #1;
        check("clr_hi9", bus.rd_color, 3'd2);
        read_all(1'b0, 3'd0);
        bus.blank = 1'b1;
        repeat (8) step();
        check("clr_done_busy", bus.busy, 0);
        check("clr_done_ready", bus.req_ready, 1);
        read_all(1'b1, 3'b010);

        // Reset during the fill sweep
        bus.clr_req   = 1'b1;
        bus.clr_color = 3'd3;
        step();
        bus.clr_req = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstclr_busy", bus.busy, 0);
        read_all(1'b1, 3'd0);
        repeat (5) step();
        read_all(1'b1, 3'd0);
`endif

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst           = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 7) == 0) bus.blank = ~bus.blank;
            bus.req_valid = $urandom_range(0, 1) == 1;
            bus.req_pos   = 4'($urandom);
            bus.req_color = 3'($urandom);
            bus.clr_req   = ($urandom_range(0, 39) == 0);
            bus.clr_color = 3'($urandom);
            bus.rd_pos    = 4'($urandom);
            step();
        end
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.clr_req   = 1'b0;
        bus.blank     = 1'b1;
        repeat (40) step();
        check("final_busy", bus.busy, 0);
        read_all(1'b0, 3'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
